// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed,
// continuous gate window of GATE_CYCLES clk cycles. Back-to-back windows have no
// gap between them, so every input edge lands in exactly one window.
// Optional build macro FREQ_METER_HOLD_EN: an unacknowledged result is held.
// Later windows are then dropped, and each dropped window is remembered in a
// sticky lost bit. That bit is folded into ovf on the next accepted update.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fin,
  input  logic             ack,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam logic [31:0]      LAST    = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             fin_edge;
  logic [31:0]      timer, timer_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_fin;
  logic             sat, sat_nxt, sat_fin;
  logic             done;
  logic             lost;
  logic             accept;

  // Synchronize fin into the clk domain and keep one extra stage for edge detect.
  // NOTE: non-blocking assignments make every flop sample the pre-edge values,
  // so the three stages really shift instead of collapsing into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= fin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fin_edge = s2 & ~s3;

  // The count including this cycle's edge, saturating at the top value.
  assign cnt_fin = (fin_edge && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
  assign sat_fin = sat | (fin_edge & (cnt == CNT_MAX));

  // Next-state logic for the gate FSM, timer and edge counter.
  // NOTE: every signal gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        cnt_nxt   = '0;
        sat_nxt   = 1'b0;
        if (en) state_nxt = GATE;
      end
      GATE: begin
        busy = 1'b1;
        if (timer == LAST) begin
          // The last cycle's edge belongs to this window. The next window starts clean.
          done      = 1'b1;
          timer_nxt = '0;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
          if (!en) state_nxt = IDLE;
        end else if (!en) begin
          // Abort: the partial count is thrown away.
          state_nxt = IDLE;
          timer_nxt = '0;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
        end else begin
          timer_nxt = timer + 32'd1;
          cnt_nxt   = cnt_fin;
          sat_nxt   = sat_fin;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, gate timer and edge counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
    end
  end

`ifdef FREQ_METER_HOLD_EN
  // A pending result blocks new ones unless it is being acknowledged right now.
  assign accept = ~valid | ack;

  // Remember any completed window that could not be reported.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    lost <= 1'b0;
    else if (done) lost <= ~accept;
  end
`else
  assign accept = 1'b1;
  assign lost   = 1'b0;
`endif

  // Result registers: load on window completion, otherwise let ack clear valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else if (done && accept) begin
      freq  <= cnt_fin;
      ovf   <= sat_fin | lost;
      valid <= 1'b1;
    end else if (ack && !done) begin
      valid <= 1'b0;
    end
  end

endmodule
